// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the sram request arbiter and its owner FIFO.
package sram_arb_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_DEPTH) + 1;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// DEPTH x 1-bit circular FIFO remembering which requester owns each accepted transaction.
module arb_owner_fifo
  import sram_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  owner_t        push_owner,
  input  logic          pop,
  output owner_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign head  = owner_t'(mem_q[rd_ptr_q]);

  // Next-state for storage, pointers and occupancy; overflow/underflow requests are ignored.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_owner;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= {DEPTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between inst and data requesters with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for round-robin unlocked pick; default is data-over-inst priority.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);

  localparam int unsigned CW = cnt_w(DEPTH);

  owner_t        fifo_head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          no_room_s;

  owner_t pick_owner_s;
  owner_t grant_owner_s;
  logic   grant_vld_s;
  logic   accept_s;
  logic   pop_s;

  logic   lock_q, lock_d;
  owner_t lock_owner_q, lock_owner_d;
  logic   proto_err_q, proto_err_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;
`endif

  assign no_room_s = fifo_full_s | (fifo_count_s >= CW'(DEPTH));

  // Unlocked pick between simultaneous requesters.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_req && data_req) begin
      pick_owner_s = (last_q == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    end else if (data_req) begin
      pick_owner_s = OWNER_DATA;
    end else begin
      pick_owner_s = OWNER_INST;
    end
`else
    if (data_req) begin
      pick_owner_s = OWNER_DATA;
    end else begin
      pick_owner_s = OWNER_INST;
    end
`endif
  end

  // Grant: a stalled handshake keeps its owner until mem_addr_ok; no grant without FIFO room.
  always_comb begin
    grant_vld_s   = 1'b0;
    grant_owner_s = OWNER_DATA;
    if (reset || no_room_s) begin
      grant_vld_s = 1'b0;
    end else if (lock_q) begin
      grant_owner_s = lock_owner_q;
      grant_vld_s   = (lock_owner_q == OWNER_DATA) ? data_req : inst_req;
    end else begin
      grant_owner_s = pick_owner_s;
      grant_vld_s   = inst_req | data_req;
    end
  end

  // Downstream request mux and per-requester address handshake.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_wstrb    = 4'd0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_wdata    = {DATA_W{1'b0}};
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (grant_vld_s) begin
      mem_req = 1'b1;
      case (grant_owner_s)
        OWNER_INST: begin
          mem_wr       = inst_wr;
          mem_size     = inst_size;
          mem_wstrb    = inst_wstrb;
          mem_addr     = inst_addr;
          mem_wdata    = inst_wdata;
          inst_addr_ok = mem_addr_ok;
        end
        OWNER_DATA: begin
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_wstrb    = data_wstrb;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

  assign accept_s = grant_vld_s & mem_addr_ok;

  // Response routing to the owner at the FIFO head.
  always_comb begin
    pop_s        = mem_data_ok & ~fifo_empty_s & ~reset;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    if (pop_s) begin
      case (fifo_head_s)
        OWNER_INST: inst_data_ok = 1'b1;
        OWNER_DATA: data_data_ok = 1'b1;
        default:    inst_data_ok = 1'b0;
      endcase
    end else begin
      inst_data_ok = 1'b0;
    end
    if (reset) begin
      inst_rdata = {DATA_W{1'b0}};
      data_rdata = {DATA_W{1'b0}};
    end else begin
      inst_rdata = mem_rdata;
      data_rdata = mem_rdata;
    end
  end

  // Next-state for lock, sticky protocol error and round-robin history.
  always_comb begin
    lock_d       = 1'b0;
    lock_owner_d = lock_owner_q;
    if (grant_vld_s && !mem_addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = grant_owner_s;
    end else begin
      lock_d = 1'b0;
    end
    proto_err_d = proto_err_q | (mem_data_ok & fifo_empty_s);
`ifdef ARB_ROUND_ROBIN_EN
    last_d = accept_s ? grant_owner_s : last_q;
`endif
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_DATA;
      proto_err_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= OWNER_DATA;
`endif
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      proto_err_q  <= proto_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign proto_err = proto_err_q;

  arb_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept_s),
    .push_owner (grant_owner_s),
    .pop        (pop_s),
    .head       (fifo_head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (fifo_count_s)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: expected grants/responses queued at stimulus, checked by a monitor.
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  sram_req_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] val;
  } exp_t;

  exp_t exp_acc[$];
  exp_t exp_rsp[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_acc(input owner_t o, input logic [31:0] a);
    exp_acc.push_back({o, a});
  endtask

  task automatic push_rsp(input owner_t o, input logic [31:0] d);
    exp_rsp.push_back({o, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input owner_t o, input logic v);
    if (o == OWNER_DATA) data_req = v;
    else inst_req = v;
  endtask

  function automatic logic [31:0] addr_of(input owner_t o);
    return (o == OWNER_DATA) ? 32'h0000_2000 : 32'h0000_1000;
  endfunction

  // Monitor: every handshake or response the DUT presents is matched against the queues.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (inst_addr_ok || data_addr_ok) begin
        check("addr_ok_exclusive", {63'd0, inst_addr_ok & data_addr_ok}, 64'd0);
        if (exp_acc.size() == 0) begin
          check("unexpected_addr_ok", 64'd1, 64'd0);
        end else begin
          e = exp_acc.pop_front();
          check("grant_owner", {63'd0, data_addr_ok}, {63'd0, e.owner});
          check("grant_addr", {32'd0, mem_addr}, {32'd0, e.val});
        end
      end
      if (inst_data_ok || data_data_ok) begin
        check("data_ok_exclusive", {63'd0, inst_data_ok & data_data_ok}, 64'd0);
        if (exp_rsp.size() == 0) begin
          check("unexpected_data_ok", 64'd1, 64'd0);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_owner", {63'd0, data_data_ok}, {63'd0, e.owner});
          check("rsp_rdata", {32'd0, data_data_ok ? data_rdata : inst_rdata}, {32'd0, e.val});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    owner_t first, second;
    owner_t fill_seq [4];
    logic [31:0] tail_rd [4];
    fill_seq = '{OWNER_INST, OWNER_DATA, OWNER_DATA, OWNER_INST};
    tail_rd  = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};

    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_wstrb = 4'd0;
    inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;

    sample();
    check("reset_mem_req", {63'd0, mem_req}, 64'd0);
    check("reset_proto_err", {63'd0, proto_err}, 64'd0);
    step();
    reset = 1'b0;
    sample();
    check("idle_mem_req", {63'd0, mem_req}, 64'd0);
    step();

    // single inst read, response three cycles after accept
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = SIZE_W; mem_addr_ok = 1'b1;
    push_acc(OWNER_INST, 32'h1C00_0000);
    push_rsp(OWNER_INST, 32'hDEAD_BEEF);
    sample();
    check("inst_mem_size", {62'd0, mem_size}, {62'd0, SIZE_W});
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    step();
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    sample();
    check("inst_rsp_no_data_ok", {63'd0, data_data_ok}, 64'd0);
    check("inst_rsp_inst_ok", {63'd0, inst_data_ok}, 64'd1);
    step();
    mem_data_ok = 1'b0;

    // both request after an inst accept: data first in both builds
    inst_req = 1'b1; data_req = 1'b1; inst_addr = addr_of(OWNER_INST); data_addr = addr_of(OWNER_DATA);
    mem_addr_ok = 1'b1;
    push_acc(OWNER_DATA, addr_of(OWNER_DATA));
    sample();
    step();
    data_req = 1'b0;
    push_acc(OWNER_INST, addr_of(OWNER_INST));
    sample();
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    push_rsp(OWNER_DATA, 32'h1111_1111);
    sample();
    step();
    mem_rdata = 32'h2222_2222;
    push_rsp(OWNER_INST, 32'h2222_2222);
    sample();
    step();
    mem_data_ok = 1'b0;

    // fresh reset: round-robin history points at data
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    first = OWNER_INST; second = OWNER_DATA;
`else
    first = OWNER_DATA; second = OWNER_INST;
`endif
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    push_acc(first, addr_of(first));
    sample();
    step();
    set_req(first, 1'b0);
    push_acc(second, addr_of(second));
    sample();
    step();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h3333_3333;
    push_rsp(first, 32'h3333_3333);
    sample();
    step();
    mem_rdata = 32'h4444_4444;
    push_rsp(second, 32'h4444_4444);
    sample();
    step();
    mem_data_ok = 1'b0;

    // lock: data stalls three cycles while inst also requests
    data_req = 1'b1; data_addr = 32'h0000_3000; data_wr = 1'b1; data_wstrb = 4'hF;
    data_wdata = 32'hCAFE_0001; mem_addr_ok = 1'b0;
    sample();
    check("lock_c1_mem_req", {63'd0, mem_req}, 64'd1);
    check("lock_c1_addr", {32'd0, mem_addr}, 64'h3000);
    step();
    inst_req = 1'b1; inst_addr = 32'h0000_4000;
    sample();
    check("lock_c2_addr", {32'd0, mem_addr}, 64'h3000);
    check("lock_c2_wr", {63'd0, mem_wr}, 64'd1);
    check("lock_c2_inst_addr_ok", {63'd0, inst_addr_ok}, 64'd0);
    step();
    sample();
    check("lock_c3_addr", {32'd0, mem_addr}, 64'h3000);
    check("lock_c3_wdata", {32'd0, mem_wdata}, 64'hCAFE_0001);
    step();
    mem_addr_ok = 1'b1;
    push_acc(OWNER_DATA, 32'h0000_3000);
    sample();
    check("lock_accept_wstrb", {60'd0, mem_wstrb}, 64'hF);
    step();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0;
    push_acc(OWNER_INST, 32'h0000_4000);
    sample();
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    push_rsp(OWNER_DATA, 32'h5555_5555);
    sample();
    step();
    mem_rdata = 32'h6666_6666;
    push_rsp(OWNER_INST, 32'h6666_6666);
    sample();
    step();
    mem_data_ok = 1'b0;

    // fill the owner FIFO: inst, data, data, inst
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_req = (fill_seq[i] == OWNER_INST);
      data_req = (fill_seq[i] == OWNER_DATA);
      inst_addr = 32'h0000_5000 + 32'(i * 4);
      data_addr = 32'h0000_5000 + 32'(i * 4);
      push_acc(fill_seq[i], 32'h0000_5000 + 32'(i * 4));
      push_rsp(fill_seq[i], 32'hA000_0000 + 32'(i));
      sample();
      step();
    end
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_6000;
    sample();
    check("full_no_mem_req", {63'd0, mem_req}, 64'd0);
    check("full_no_addr_ok", {63'd0, data_addr_ok}, 64'd0);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'hA000_0000;
    sample();
    check("full_pop_no_grant", {63'd0, mem_req}, 64'd0);
    step();
    mem_data_ok = 1'b0;
    push_acc(OWNER_DATA, 32'h0000_6000);
    push_rsp(OWNER_DATA, 32'hA000_0004);
    sample();
    check("after_pop_grant", {63'd0, mem_req}, 64'd1);
    step();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int j = 0; j < 4; j++) begin
      mem_data_ok = 1'b1; mem_rdata = tail_rd[j];
      sample();
      step();
    end
    mem_data_ok = 1'b0;

    // response with empty FIFO
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0BAD;
    sample();
    check("empty_rsp_inst_ok", {63'd0, inst_data_ok}, 64'd0);
    check("empty_rsp_data_ok", {63'd0, data_data_ok}, 64'd0);
    step();
    mem_data_ok = 1'b0;
    sample();
    check("proto_err_set", {63'd0, proto_err}, 64'd1);
    step();
    step();
    sample();
    check("proto_err_sticky", {63'd0, proto_err}, 64'd1);
    step();

    // two outstanding, then asynchronous reset mid-cycle
    inst_req = 1'b1; inst_addr = 32'h0000_7000; mem_addr_ok = 1'b1;
    push_acc(OWNER_INST, 32'h0000_7000);
    sample();
    step();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_7004;
    push_acc(OWNER_DATA, 32'h0000_7004);
    sample();
    step();
    data_req = 1'b0; inst_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mem_req", {63'd0, mem_req}, 64'd0);
    check("async_reset_addr_ok", {63'd0, inst_addr_ok}, 64'd0);
    check("async_reset_proto_err", {63'd0, proto_err}, 64'd0);
    check("async_reset_mem_addr", {32'd0, mem_addr}, 64'd0);
    step();
    reset = 1'b0; inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0777;
    sample();
    check("stale_rsp_inst_ok", {63'd0, inst_data_ok}, 64'd0);
    check("stale_rsp_data_ok", {63'd0, data_data_ok}, 64'd0);
    step();
    mem_data_ok = 1'b0;
    sample();
    check("stale_rsp_proto_err", {63'd0, proto_err}, 64'd1);

    check("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Shares one sram-like memory port between the instruction-fetch requester and the data (load/store) requester of the pipeline. Grants one address handshake per cycle and records the owner of every accepted transaction in an in-order owner FIFO. Routes each returning data_ok/rdata to the requester that issued it. Sits between the IF/EXE request logic and the AXI bridge; the MEM stage consumes data_data_ok exactly as it consumed data_sram_data_ok.

## Interface
- DEPTH, 4, max outstanding accepted-but-unanswered transactions (power of 2, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- inst_req / data_req  in  1  request valid; held until the matching addr_ok
- inst_wr / data_wr  in  1  1 = write
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_wstrb / data_wstrb  in  4  byte strobes
- inst_addr / data_addr  in  ADDR_W  address
- inst_wdata / data_wdata  in  DATA_W  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle
- inst_rdata / data_rdata  out  DATA_W  read data (mem_rdata broadcast)
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/ADDR_W/DATA_W  downstream request
- mem_addr_ok  in  1  downstream accepted request
- mem_data_ok  in  1  downstream response, strictly in acceptance order
- mem_rdata  in  DATA_W  downstream read data
- proto_err  out  1  sticky: mem_data_ok received with owner FIFO empty

## Operation
- Candidate set: requesters with req = 1. No grant while owner FIFO is full (count == DEPTH), even if a pop occurs in the same cycle.
- Lock: when mem_req = 1 and mem_addr_ok = 0, a lock register holds the current owner; the next cycle grants the same owner regardless of the other request. Lock clears on the cycle mem_addr_ok = 1.
- Unlocked pick: data wins over inst (fixed priority; see Configuration).
- mem_req = granted req; mem_wr/size/wstrb/addr/wdata muxed from the granted requester. All are 0 when there is no grant.
- Granted requester's addr_ok = mem_addr_ok; the other requester's addr_ok = 0.
- Accept (mem_req & mem_addr_ok): push owner ID into the FIFO.
- Response (mem_data_ok): pop the head and assert the head owner's data_ok. rdata is broadcast to both ports.
- mem_data_ok with an empty FIFO: no pop, no data_ok, proto_err ← 1 until reset.
- Push and pop in the same cycle (not full): count unchanged, pointers both advance.

## Timing
- Request path is combinational: req → mem_req and mem_addr_ok → *_addr_ok in the same cycle.
- Response path is combinational: mem_data_ok → *_data_ok in the same cycle. Arbiter adds zero latency.
- Owner FIFO, lock and proto_err update on posedge clk.
- Reset (async, any time, including mid-lock or with outstanding entries):
  - FIFO empty, pointers 0, lock clear, RR pointer = data, proto_err = 0.
  - All outputs 0 while reset is asserted and until a req arrives.
- In-flight responses arriving after reset are treated as the empty-FIFO case.

## Configuration
- ARB_ROUND_ROBIN_EN defined: unlocked pick is round-robin. A 1-bit last-granted register flips to the other owner after every accept, so the non-last owner wins when both request.
- Not defined: fixed data-over-inst priority and no RR register.
- Lock, FIFO and error behaviour are identical in both builds.

## Structure
- Package sram_arb_pkg:
  - owner_t (OWNER_INST = 1'b0, OWNER_DATA = 1'b1)
  - size codes SIZE_B/SIZE_H/SIZE_W
  - localparam CNT_W = $clog2(DEPTH)+1
- One sub-module, arb_owner_fifo: DEPTH × 1-bit circular FIFO with push, pop, head, full, empty and count; async reset.

## Test plan
- Single inst read at 0x1C000000, mem_addr_ok same cycle, mem_data_ok 3 cycles later with rdata 0xDEADBEEF → inst_addr_ok 1 cycle, inst_data_ok 1 cycle with inst_rdata 0xDEADBEEF, data_data_ok stays 0.
- inst_req and data_req both high, mem_addr_ok = 1 → data granted first, inst next cycle. With ARB_ROUND_ROBIN_EN and last = data, inst is granted first.
- Data granted with mem_addr_ok low for 3 cycles while inst also requests → mem_addr stays data_addr all 3 cycles; inst is granted only after the accept.
- Issue 4 accepts without responses (DEPTH = 4) → 5th request sees mem_req = 0. One mem_data_ok pops; the next cycle's grant succeeds. Response order inst, data, data, inst is routed exactly.
- mem_data_ok with empty FIFO → no *_data_ok, proto_err = 1 and stays 1. Assert reset with 2 entries outstanding → FIFO empty, proto_err = 0, outputs 0 immediately.
